rip_mem_responder: RTL and testbench

RIP_MEM_RESPONDER -- requirements
Module: rip_mem_responder

---
 rtl/rip_mem_responder.sv | 150 +++++++++++++++
 tb/tb_rip_mem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rip_mem_responder.sv
// Single-outstanding memory responder: accepts one load/store at a time, waits a
// fixed number of cycles, then presents the response until it is consumed.
module rip_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_8000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t          state_reg;
  logic [3:0]      cnt_reg;
  logic            lat_we_reg;
  logic            lat_err_reg;
  logic [AW-1:0]   lat_idx_reg;
  logic [31:0]     lat_wdata_reg;
  logic [3:0]      lat_wstrb_reg;
  logic            rsp_err_reg;
  logic            rsp_load_reg;

  logic            in_err;
  logic [AW-1:0]   in_idx;
  logic            accept;
  logic            commit;
  logic            in_idle;
  logic            cur_we;
  logic            cur_err;
  logic [AW-1:0]   cur_idx;
  logic [31:0]     cur_wdata;
  logic [3:0]      cur_wstrb;
  logic            wr_en;
  logic            rd_en;
  logic [3:0][7:0] rd_lanes;

  // 33-bit compare so BASE_ADDR + size cannot wrap around the address space.
  assign in_err = (req_addr[1:0] != 2'b00)
               || ({1'b0, req_addr} < {1'b0, BASE_ADDR})
               || ({1'b0, req_addr} >= LIMIT);
  assign in_idx = AW'((req_addr - BASE_ADDR) >> 2);

  assign in_idle   = (state_reg == ST_IDLE);
  assign req_ready = in_idle && !rst;
  assign accept    = req_valid && req_ready;

  // With zero latency the commit happens on the acceptance edge itself, so the
  // live request inputs feed the RAM; otherwise the latched copy does.
  assign cur_we    = in_idle ? req_we    : lat_we_reg;
  assign cur_err   = in_idle ? in_err    : lat_err_reg;
  assign cur_idx   = in_idle ? in_idx    : lat_idx_reg;
  assign cur_wdata = in_idle ? req_wdata : lat_wdata_reg;
  assign cur_wstrb = in_idle ? req_wstrb : lat_wstrb_reg;

  assign commit = (accept && (LATENCY == 0))
               || ((state_reg == ST_WAIT) && (cnt_reg == 4'd0) && !rst);
  assign wr_en  = commit && cur_we && !cur_err;
  assign rd_en  = commit && !cur_we && !cur_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 4'd0;
      lat_we_reg    <= 1'b0;
      lat_err_reg   <= 1'b0;
      lat_idx_reg   <= '0;
      lat_wdata_reg <= 32'd0;
      lat_wstrb_reg <= 4'd0;
      rsp_err_reg   <= 1'b0;
      rsp_load_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            lat_we_reg    <= req_we;
            lat_err_reg   <= in_err;
            lat_idx_reg   <= in_idx;
            lat_wdata_reg <= req_wdata;
            lat_wstrb_reg <= req_wstrb;
            if (LATENCY == 0) begin
              state_reg    <= ST_RESP;
              rsp_err_reg  <= in_err;
              rsp_load_reg <= !req_we && !in_err;
            end else begin
              state_reg <= ST_WAIT;
              cnt_reg   <= LAT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg    <= ST_RESP;
            rsp_err_reg  <= lat_err_reg;
            rsp_load_reg <= !lat_we_reg && !lat_err_reg;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_reg    <= ST_IDLE;
            rsp_err_reg  <= 1'b0;
            rsp_load_reg <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // One byte-wide RAM per lane gives byte enables without read-modify-write.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
        if (wr_en && cur_wstrb[gi]) begin
          mem[cur_idx] <= cur_wdata[8*gi +: 8];
        end
        if (rd_en) begin
          rd_q <= mem[cur_idx];
        end
      end

      assign rd_lanes[gi] = rd_q;
    end
  endgenerate

  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_load_reg ? rd_lanes : 32'd0;

endmodule

// File: tb/tb_rip_mem_responder.sv
// Directed bench for rip_mem_responder: four instances at latencies 1, 0, 15 and 3
// exercised with hand-computed loads, stores, boundary addresses and resets.
module tb_rip_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst       [4];
  logic        req_valid [4];
  logic        req_ready [4];
  logic        req_we    [4];
  logic [31:0] req_addr  [4];
  logic [31:0] req_wdata [4];
  logic [3:0]  req_wstrb [4];
  logic        rsp_valid [4];
  logic        rsp_ready [4];
  logic [31:0] rsp_rdata [4];
  logic        rsp_err   [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      rip_mem_responder #(
        .BASE_ADDR  (32'h0000_8000),
        .DEPTH_WORDS(1024),
        .LATENCY    ((gi == 0) ? 1 : (gi == 1) ? 0 : (gi == 2) ? 15 : 3)
      ) u_dut (
        .clk      (clk),
        .rst      (rst[gi]),
        .req_valid(req_valid[gi]),
        .req_ready(req_ready[gi]),
        .req_we   (req_we[gi]),
        .req_addr (req_addr[gi]),
        .req_wdata(req_wdata[gi]),
        .req_wstrb(req_wstrb[gi]),
        .rsp_valid(rsp_valid[gi]),
        .rsp_ready(rsp_ready[gi]),
        .rsp_rdata(rsp_rdata[gi]),
        .rsp_err  (rsp_err[gi])
      );
    end
  endgenerate

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request; inputs are scrambled after acceptance to prove they were latched.
  // Returns at the negedge where rsp_valid is first seen.
  task automatic xact(input string tag, input int k, input logic we,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                      input logic exp_err, input int exp_lat, input logic bp);
    int n;
    int lat;
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_wstrb[k] = wstrb;
    rsp_ready[k] = !bp;
    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, 32'(req_ready[k]), 32'd1);
    @(negedge clk);
    req_valid[k] = 1'b0;
    req_we[k]    = !we;
    req_addr[k]  = ~addr;
    req_wdata[k] = ~wdata;
    req_wstrb[k] = ~wstrb;
    lat = 1;
    while (!rsp_valid[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    $display("xact %s inst=%0d we=%0d addr=%h rdata=%h err=%0d lat=%0d",
             tag, k, we, addr, rsp_rdata[k], rsp_err[k], lat);
    chk({tag, "_rdata"}, rsp_rdata[k], exp_rdata);
    chk({tag, "_err"}, 32'(rsp_err[k]), 32'(exp_err));
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  // Hold a load request continuously and measure the spacing of acceptances.
  task automatic spacing(input string tag, input int k, input int exp_gap);
    int first;
    int gap;
    int hits;
    int n;
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_we[k]    = 1'b0;
    req_addr[k]  = 32'h0000_8000;
    rsp_ready[k] = 1'b1;
    first = 0;
    gap   = -1;
    hits  = 0;
    n     = 0;
    while (hits < 2 && n < 100) begin
      if (req_ready[k]) begin
        if (hits == 0) first = cyc;
        else gap = cyc - first;
        hits++;
      end
      @(negedge clk);
      n++;
    end
    req_valid[k] = 1'b0;
    $display("xact %s inst=%0d accept_gap=%0d", tag, k, gap);
    chk(tag, 32'(gap), 32'(exp_gap));
    repeat (20) @(negedge clk);
  endtask

  initial begin
    logic seen;
    for (int k = 0; k < 4; k++) begin
      rst[k]       = 1'b1;
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = 32'd0;
      req_wdata[k] = 32'd0;
      req_wstrb[k] = 4'd0;
      rsp_ready[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("rst_ready", 32'(req_ready[k]), 32'd0);
      chk("rst_valid", 32'(rsp_valid[k]), 32'd0);
      chk("rst_rdata", rsp_rdata[k], 32'd0);
      chk("rst_err", 32'(rsp_err[k]), 32'd0);
      rst[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 4; k++) chk("ready_after_rst", 32'(req_ready[k]), 32'd1);

    // Latency 1: full and partial stores, zero strobe, boundaries.
    xact("st_full",   0, 1'b1, 32'h0000_8004, 32'hDEAD_BEEF, 4'hF, 32'h0,          1'b0, 2, 1'b0);
    xact("ld_full",   0, 1'b0, 32'h0000_8004, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0, 2, 1'b0);
    xact("st_part",   0, 1'b1, 32'h0000_8004, 32'h1122_3344, 4'h5, 32'h0,          1'b0, 2, 1'b0);
    xact("ld_part",   0, 1'b0, 32'h0000_8004, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0, 2, 1'b0);
    xact("st_nostrb", 0, 1'b1, 32'h0000_8004, 32'hFFFF_FFFF, 4'h0, 32'h0,          1'b0, 2, 1'b0);
    xact("ld_nostrb", 0, 1'b0, 32'h0000_8004, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0, 2, 1'b0);
    xact("st_w0",     0, 1'b1, 32'h0000_8000, 32'h0102_0304, 4'hF, 32'h0,          1'b0, 2, 1'b0);
    xact("st_last",   0, 1'b1, 32'h0000_8FFC, 32'hCAFE_F00D, 4'hF, 32'h0,          1'b0, 2, 1'b0);
    xact("ld_last",   0, 1'b0, 32'h0000_8FFC, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0, 2, 1'b0);
    xact("ld_over",   0, 1'b0, 32'h0000_9000, 32'h0,         4'h0, 32'h0,          1'b1, 2, 1'b0);
    xact("ld_under",  0, 1'b0, 32'h0000_7FFC, 32'h0,         4'h0, 32'h0,          1'b1, 2, 1'b0);
    xact("ld_misal",  0, 1'b0, 32'h0000_8002, 32'h0,         4'h0, 32'h0,          1'b1, 2, 1'b0);
    xact("st_over",   0, 1'b1, 32'h0000_9000, 32'hBADB_AD00, 4'hF, 32'h0,          1'b1, 2, 1'b0);
    xact("st_misal",  0, 1'b1, 32'h0000_8001, 32'hBADB_AD11, 4'hF, 32'h0,          1'b1, 2, 1'b0);
    xact("ld_w0",     0, 1'b0, 32'h0000_8000, 32'h0,         4'h0, 32'h0102_0304, 1'b0, 2, 1'b0);
    xact("ld_last2",  0, 1'b0, 32'h0000_8FFC, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0, 2, 1'b0);

    // Backpressure: response must hold while rsp_ready is low.
    xact("ld_bp",     0, 1'b0, 32'h0000_8004, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0, 2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid[0]), 32'd1);
      chk("bp_rdata", rsp_rdata[0], 32'hDE22_BE44);
      chk("bp_ready", 32'(req_ready[0]), 32'd0);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(rsp_valid[0]), 32'd0);
    chk("bp_release_ready", 32'(req_ready[0]), 32'd1);

    // Latency 0 and 15: response timing and acceptance spacing.
    xact("l0_st", 1, 1'b1, 32'h0000_8000, 32'hA5A5_A5A5, 4'hF, 32'h0,          1'b0, 1, 1'b0);
    xact("l0_ld", 1, 1'b0, 32'h0000_8000, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0, 1, 1'b0);
    spacing("l0_gap", 1, 2);
    xact("l15_st", 2, 1'b1, 32'h0000_8000, 32'h5A5A_0000, 4'hF, 32'h0,          1'b0, 16, 1'b0);
    xact("l15_ld", 2, 1'b0, 32'h0000_8000, 32'h0,         4'h0, 32'h5A5A_0000, 1'b0, 16, 1'b0);
    spacing("l15_gap", 2, 17);

    // Latency 3: reset on the would-be commit edge of a store.
    xact("l3_st", 3, 1'b1, 32'h0000_8010, 32'h1234_5678, 4'hF, 32'h0,          1'b0, 4, 1'b0);
    xact("l3_ld", 3, 1'b0, 32'h0000_8010, 32'h0,         4'h0, 32'h1234_5678, 1'b0, 4, 1'b0);
    @(negedge clk);
    req_valid[3] = 1'b1;
    req_we[3]    = 1'b1;
    req_addr[3]  = 32'h0000_8010;
    req_wdata[3] = 32'h8765_4321;
    req_wstrb[3] = 4'hF;
    chk("rw_ready", 32'(req_ready[3]), 32'd1);
    @(negedge clk);
    req_valid[3] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rw_wait_valid", 32'(rsp_valid[3]), 32'd0);
    rst[3] = 1'b1;
    @(negedge clk);
    chk("rw_rst_valid", 32'(rsp_valid[3]), 32'd0);
    chk("rw_rst_ready", 32'(req_ready[3]), 32'd0);
    chk("rw_rst_err", 32'(rsp_err[3]), 32'd0);
    chk("rw_rst_rdata", rsp_rdata[3], 32'd0);
    @(negedge clk);
    rst[3] = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[3]) seen = 1'b1;
    end
    chk("rw_no_rsp", 32'(seen), 32'd0);
    xact("rw_ld", 3, 1'b0, 32'h0000_8010, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 4, 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
